// File: rtl/tx_burst_stream_if.sv
// Handshake and FIFO-write bundle for tx_burst_stream.
// The parity_o signal exists only when TX_PARITY_EN is defined.
interface tx_burst_stream_if #(
    parameter int unsigned N       = 4,
    parameter int unsigned MAX_LEN = 16
);
    localparam int unsigned L = $clog2(MAX_LEN + 1);

    logic         wr_en_i;
    logic [N-1:0] wr_data_i;
    logic         tx;
    logic [L-1:0] len_i;
    logic         ready_i;
    logic         valid_o;
    logic [N-1:0] data_o;
    logic         last_o;
    logic         busy_o;
    logic         full_o;
    logic         empty_o;
`ifdef TX_PARITY_EN
    logic         parity_o;
`endif

    // Transmitter side.
    modport master (
        input  wr_en_i, wr_data_i, tx, len_i, ready_i,
        output valid_o, data_o, last_o, busy_o, full_o, empty_o
`ifdef TX_PARITY_EN
        , output parity_o
`endif
    );

    // Producer / consumer side.
    modport slave (
        output wr_en_i, wr_data_i, tx, len_i, ready_i,
        input  valid_o, data_o, last_o, busy_o, full_o, empty_o
`ifdef TX_PARITY_EN
        , input parity_o
`endif
    );
endinterface

// File: rtl/tx_burst_stream.sv
// Burst transmitter: buffers words in a FIFO and streams len_i of them per tx pulse
// over valid/ready. Optional even-parity output enabled by macro TX_PARITY_EN.
module tx_burst_stream #(
    parameter int unsigned N       = 4,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned MAX_LEN = 16
) (
    input logic                clk,
    input logic                rst,
    tx_burst_stream_if.master  bus
);
    localparam int unsigned L  = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StValid} state_e;

    state_e         state_q;
    logic [L-1:0]   rem_q;
    logic [N-1:0]   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           full_q, empty_q;
    logic           valid_q, last_q, busy_q;
    logic [N-1:0]   data_q;
    logic [N-1:0]   head;
    logic           push, pop, xfer, start;

    always_comb begin
        push  = bus.wr_en_i & ~full_q;
        xfer  = valid_q & bus.ready_i;
        start = bus.tx && (bus.len_i != '0) && (bus.len_i <= L'(MAX_LEN));
        head  = mem_q[rd_ptr_q];
        pop   = 1'b0;
        unique case (state_q)
            StLoad:  pop = ~empty_q;
            // Back-to-back pop only when more words remain in the burst.
            StValid: pop = xfer & (rem_q != L'(1)) & ~empty_q;
            default: pop = 1'b0;
        endcase
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        rem_q   <= bus.len_i;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (pop) begin
                        data_q  <= head;
                        valid_q <= 1'b1;
                        last_q  <= (rem_q == L'(1));
                        state_q <= StValid;
                    end
                end
                StValid: begin
                    if (xfer) begin
                        if (rem_q == L'(1)) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            rem_q <= rem_q - L'(1);
                            if (pop) begin
                                data_q <= head;
                                last_q <= (rem_q == L'(2));
                            end else begin
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                state_q <= StLoad;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef TX_PARITY_EN
    logic parity_q;

    // Every word load is a pop; a transfer without a pop always drops valid_o.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if (pop) begin
            parity_q <= ^head;
        end else if (xfer) begin
            parity_q <= 1'b0;
        end
    end

    assign bus.parity_o = parity_q;
`endif

    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.last_o  = last_q;
    assign bus.busy_o  = busy_q;
    assign bus.full_o  = full_q;
    assign bus.empty_o = empty_q;
endmodule
